// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic definitions for the NTT datapath: op encoding, default
// Kyber parameters and a helper that extracts one lane from a packed bus.
package ntt_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_MODULUS    = 3329;

  // Widest packed bus the slice helper accepts; callers zero-extend to this.
  localparam int BUS_MAX = 256;

  function automatic logic [31:0] lane_slice(input logic [BUS_MAX-1:0] bus,
                                             input int lane,
                                             input int width);
    logic [BUS_MAX-1:0] w_sh;
    w_sh = bus >> (lane * width);
    return w_sh[31:0] & ((32'h1 << width) - 32'h1);
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/subtract pipeline: stage 1 forms the raw
// sum/difference with its carry/borrow, stage 2 folds it back into [0, M-1].
module mod_addsub_lane
  import ntt_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en1,
  input  logic                  i_en2,
  input  logic                  i_op,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_y,
  output logic [DATA_WIDTH-1:0] o_z
);

  localparam logic [DATA_WIDTH:0] MOD_W = (DATA_WIDTH+1)'(MODULUS);

  logic [DATA_WIDTH:0]   r_sum;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_z;

  logic [DATA_WIDTH:0]   w_xe;
  logic [DATA_WIDTH:0]   w_ye;
  logic [DATA_WIDTH-1:0] w_t;
  logic [DATA_WIDTH-1:0] w_fix;
  logic [DATA_WIDTH-1:0] w_corr;

  assign w_xe = {1'b0, i_x};
  assign w_ye = {1'b0, i_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_op  <= OP_ADD;
    end else if (i_en1) begin
      r_op  <= i_op;
      r_sum <= (i_op == OP_SUB) ? (w_xe - w_ye) : (w_xe + w_ye);
    end
  end

  // Only the low DATA_WIDTH bits of r-M and r+M survive, so compute them narrow.
  assign w_t   = r_sum[DATA_WIDTH-1:0] - MOD_W[DATA_WIDTH-1:0];
  assign w_fix = r_sum[DATA_WIDTH-1:0] + MOD_W[DATA_WIDTH-1:0];

  always_comb begin
    w_corr = r_sum[DATA_WIDTH-1:0];
    if (r_op == OP_ADD) begin
      if (r_sum >= MOD_W) w_corr = w_t;
    end else if (r_sum[DATA_WIDTH]) begin
      w_corr = w_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_z <= '0;
    else if (i_en2) r_z <= w_corr;
  end

  assign o_z = r_z;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane two-stage modular adder/subtractor with valid/ready on both
// sides; the lanes share one op and one pair of stage valids.
module mod_addsub_pipe
  import ntt_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS,
  parameter int LANES      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_op,
  input  logic [LANES*DATA_WIDTH-1:0] in_x,
  input  logic [LANES*DATA_WIDTH-1:0] in_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_z
);

  logic r_v1;
  logic r_v2;
  logic w_adv1;
  logic w_adv2;
  logic w_en1;
  logic w_en2;

  logic [BUS_MAX-1:0] w_x_bus;
  logic [BUS_MAX-1:0] w_y_bus;

  assign w_adv2 = ~r_v2 | out_ready;
  assign w_adv1 = ~r_v1 | w_adv2;
  assign w_en1  = in_valid & w_adv1;
  // Stage-2 data only loads a real beat, so out_z never changes under a stall.
  assign w_en2  = w_adv2 & r_v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_v2;

  assign w_x_bus = BUS_MAX'(in_x);
  assign w_y_bus = BUS_MAX'(in_y);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_x;
    logic [DATA_WIDTH-1:0] w_y;
    logic [DATA_WIDTH-1:0] w_z;

    assign w_x = DATA_WIDTH'(lane_slice(w_x_bus, gi, DATA_WIDTH));
    assign w_y = DATA_WIDTH'(lane_slice(w_y_bus, gi, DATA_WIDTH));

    mod_addsub_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .MODULUS   (MODULUS)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en1(w_en1),
      .i_en2(w_en2),
      .i_op (in_op),
      .i_x  (w_x),
      .i_y  (w_y),
      .o_z  (w_z)
    );

    assign out_z[gi*DATA_WIDTH +: DATA_WIDTH] = w_z;
  end

endmodule
